// File: rtl/pixel_vector_storer.sv
// Copies one 4-lane pixel vector from a two-slot bank into data memory as four
// consecutive write beats starting at a captured base address.
module pixel_vector_storer #(
  parameter int W      = 32,
  parameter int STRIDE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         vec_pos,
  input  logic [W-1:0] base_addr,
  output logic         rd_pos,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  output logic [W-1:0] mem_addr,
  output logic [W-1:0] mem_wd,
  output logic         mem_we,
  input  logic         mem_ready,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  logic         r_slot;
  logic [W-1:0] r_addr;
  logic [W-1:0] r_buf [4];
  logic [1:0]   r_lane;
  logic [W-1:0] r_mem_addr;
  logic [W-1:0] r_mem_wd;
  logic         r_mem_we;
  logic         r_busy;
  logic         r_done;

  logic         w_beat;
  logic [W-1:0] w_next_addr;
  logic [1:0]   w_next_lane;

  // Handshake: a beat transfers on an edge where mem_we and mem_ready are both
  // high; while mem_ready is low the presented address/data/we stay unchanged.
  assign w_beat      = r_mem_we & mem_ready;
  assign w_next_addr = r_addr + W'(STRIDE);
  assign w_next_lane = r_lane + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_slot     <= 1'b0;
      r_addr     <= '0;
      r_lane     <= 2'd0;
      r_mem_addr <= '0;
      r_mem_wd   <= '0;
      r_mem_we   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_slot  <= vec_pos;
            r_addr  <= base_addr;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Snapshot of the bank: later bank writes do not reach memory.
          r_buf[0]   <= in1;
          r_buf[1]   <= in2;
          r_buf[2]   <= in3;
          r_buf[3]   <= in4;
          r_lane     <= 2'd0;
          r_mem_addr <= r_addr;
          r_mem_wd   <= in1;
          r_mem_we   <= 1'b1;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          if (w_beat) begin
            r_addr <= w_next_addr;
            r_lane <= w_next_lane;
            if (r_lane == 2'd3) begin
              r_mem_we <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_mem_addr <= w_next_addr;
              r_mem_wd   <= r_buf[w_next_lane];
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_pos    = r_slot;
  assign mem_addr  = r_mem_addr;
  assign mem_wd    = r_mem_wd;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pixel_vector_storer.sv
// Bench for pixel_vector_storer: directed vector table, hand-written corner
// sequences, and randomized transfers against a reference model.
module tb_pixel_vector_storer;
  localparam int W      = 32;
  localparam int STRIDE = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         vec_pos;
  logic [W-1:0] base_addr;
  logic         rd_pos;
  logic [W-1:0] in1, in2, in3, in4;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wd;
  logic         mem_we;
  logic         mem_ready;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  logic [W-1:0] bank [2][4];

  pixel_vector_storer #(.W(W), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_pos(vec_pos),
    .base_addr(base_addr), .rd_pos(rd_pos),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .mem_ready(mem_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Bank read port is combinational from rd_pos.
  assign in1 = bank[rd_pos][0];
  assign in2 = bank[rd_pos][1];
  assign in3 = bank[rd_pos][2];
  assign in4 = bank[rd_pos][3];

  always #5 clk = ~clk;

  typedef struct {
    logic                slot;
    logic [W-1:0]        base;
    int                  sb;
    int                  sl;
    logic [3:0][W-1:0]   ea;
    logic [3:0][W-1:0]   ed;
    int                  exp_done;
  } vec_t;

  vec_t             vecs[$];
  logic [2*W-1:0]   exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               done_cnt = 0;
  int               beat_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe();
    logic [2*W-1:0] e;
    if (!rst && mem_we && mem_ready) begin
      beat_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got addr=%h data=%h expected no beat", mem_addr, mem_wd);
      end else begin
        e = exp_q.pop_front();
        check("beat", {mem_addr, mem_wd}, e);
      end
    end
    if (done) done_cnt++;
  endtask

  task automatic sample();
    @(negedge clk);
    observe();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic s, input logic [W-1:0] b, input int sb_, input int sl_,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input logic [W-1:0] a3,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3, input int dn);
    vec_t v;
    v.slot = s; v.base = b; v.sb = sb_; v.sl = sl_;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2; v.ed[3] = d3;
    v.exp_done = dn;
    vecs.push_back(v);
  endtask

  task automatic load_bank();
    bank[0][0] = 15; bank[0][1] = 45; bank[0][2] = 74; bank[0][3] = 82;
    bank[1][0] = 16; bank[1][1] = 46; bank[1][2] = 75; bank[1][3] = 83;
  endtask

  // One store. rnd=0: fixed stall window (sb/sl) and table latency.
  // rnd=1: random mem_ready/start noise, bank scrambled after the fetch,
  // latency predicted by counting accepted beats.
  task automatic do_store(input logic s, input logic [W-1:0] b,
                          input logic [3:0][W-1:0] ea, input logic [3:0][W-1:0] ed,
                          input int sb, input int sl, input bit rnd, input int exp_done);
    int done_cyc;
    int d0;
    int mb;
    int model_done;
    bit stalled;
    vec_pos = s; base_addr = b; start = 1'b1; mem_ready = 1'b1;
    sample();
    advance();
    start = 1'b0;
    for (int k = 0; k < 4; k++) exp_q.push_back({ea[k], ed[k]});
    done_cyc = 0; d0 = done_cnt; mb = 0; model_done = -1;
    for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
      stalled = 1'b0;
      if (rnd) begin
        mem_ready = ($urandom_range(0, 9) < 7);
        start     = ($urandom_range(0, 3) == 0);
        vec_pos   = 1'($urandom_range(0, 1));
        base_addr = $urandom;
      end else begin
        stalled   = (c >= 2 + sb) && (c < 2 + sb + sl);
        mem_ready = !stalled;
      end
      if (c >= 2 && mb < 4 && mem_ready) begin
        mb++;
        if (mb == 4) model_done = c + 1;
      end
      sample();
      check("busy_active", 64'(busy), 64'd1);
      if (c == 1) begin
        check("rd_pos_slot", 64'(rd_pos), 64'(s));
        check("we_low_in_fetch", 64'(mem_we), 64'd0);
      end
      if (stalled) check("stall_hold", {31'd0, mem_we, mem_addr, mem_wd}, {31'd0, 1'b1, ea[sb], ed[sb]});
      if (done_cnt != d0) done_cyc = c;
      advance();
      if (rnd && c == 1) begin
        for (int k = 0; k < 4; k++) begin
          bank[0][k] = $urandom;
          bank[1][k] = $urandom;
        end
      end
    end
    start = 1'b0; mem_ready = 1'b1;
    if (done_cyc == 0) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done within 300 cycles expected done");
    end else begin
      check("done_latency", 64'(done_cyc), 64'(rnd ? model_done : exp_done));
    end
    check("done_count", 64'(done_cnt - d0), 64'd1);
    sample();
    check("idle_after", {61'd0, busy, done, mem_we}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    advance();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][W-1:0] ea;
    logic [3:0][W-1:0] ed;
    logic              s;
    logic [W-1:0]      b;
    int                d0;
    int                b0;
    int                got;

    load_bank();
    add_vec(1'b0, 32'h100, 0, 0, 32'h100, 32'h104, 32'h108, 32'h10C, 15, 45, 74, 82, 6);
    add_vec(1'b1, 32'h100, 0, 0, 32'h100, 32'h104, 32'h108, 32'h10C, 16, 46, 75, 83, 6);
    add_vec(1'b0, 32'h100, 1, 3, 32'h100, 32'h104, 32'h108, 32'h10C, 15, 45, 74, 82, 9);
    add_vec(1'b0, 32'hFFFFFFF8, 0, 0, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 15, 45, 74, 82, 6);
    add_vec(1'b1, 32'hFFFFFFFC, 3, 2, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 16, 46, 75, 83, 8);
    add_vec(1'b1, 32'h20, 0, 1, 32'h20, 32'h24, 32'h28, 32'h2C, 16, 46, 75, 83, 7);

    rst = 1'b1; start = 1'b0; vec_pos = 1'b0; base_addr = '0; mem_ready = 1'b1;
    advance();
    advance();
    rst = 1'b0;
    sample();
    check("reset_ctrl", {58'd0, dbg_state, rd_pos, busy, done, mem_we}, 64'd0);
    check("reset_data", {mem_addr, mem_wd}, 64'd0);
    advance();

    foreach (vecs[i])
      do_store(vecs[i].slot, vecs[i].base, vecs[i].ea, vecs[i].ed,
               vecs[i].sb, vecs[i].sl, 1'b0, vecs[i].exp_done);

    // start pulses during WRITE and DONE are ignored; the IDLE cycle after DONE accepts.
    vec_pos = 1'b0; base_addr = 32'h100; start = 1'b1;
    sample();
    advance();
    start = 1'b0;
    exp_q.push_back({32'h100, 32'd15}); exp_q.push_back({32'h104, 32'd45});
    exp_q.push_back({32'h108, 32'd74}); exp_q.push_back({32'h10C, 32'd82});
    d0 = done_cnt;
    for (int c = 1; c <= 6; c++) begin
      start = (c == 3 || c == 6);
      vec_pos = 1'b1; base_addr = 32'h500;
      sample();
      advance();
    end
    check("ignored_start_done", 64'(done_cnt - d0), 64'd1);
    check("ignored_start_beats", 64'(exp_q.size()), 64'd0);
    start = 1'b1; vec_pos = 1'b1; base_addr = 32'h300;
    sample();
    check("idle_after_done", 64'(busy), 64'd0);
    advance();
    start = 1'b0;
    exp_q.push_back({32'h300, 32'd16}); exp_q.push_back({32'h304, 32'd46});
    exp_q.push_back({32'h308, 32'd75}); exp_q.push_back({32'h30C, 32'd83});
    got = 0; d0 = done_cnt;
    for (int c = 8; c <= 40 && got == 0; c++) begin
      sample();
      if (c == 8) check("restart_rd_pos", 64'(rd_pos), 64'd1);
      if (done_cnt != d0) got = c;
      advance();
    end
    check("restart_latency", 64'(got), 64'd13);
    check("restart_beats", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Reset after the second beat: no further beats, no done.
    vec_pos = 1'b1; base_addr = 32'h400; start = 1'b1;
    sample();
    advance();
    start = 1'b0;
    exp_q.push_back({32'h400, 32'd16}); exp_q.push_back({32'h404, 32'd46});
    exp_q.push_back({32'h408, 32'd75}); exp_q.push_back({32'h40C, 32'd83});
    for (int c = 1; c <= 3; c++) begin
      sample();
      advance();
    end
    check("beats_before_rst", 64'(exp_q.size()), 64'd2);
    rst = 1'b1; start = 1'b1;
    sample();
    advance();
    rst = 1'b0; start = 1'b0;
    exp_q.delete();
    d0 = done_cnt; b0 = beat_cnt;
    sample();
    check("midrst_ctrl", {58'd0, dbg_state, rd_pos, busy, done, mem_we}, 64'd0);
    advance();
    for (int c = 0; c < 8; c++) begin
      sample();
      advance();
    end
    check("midrst_no_beats", 64'(beat_cnt - b0), 64'd0);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);

    // Randomized transfers against the reference model.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 4; k++) begin
        bank[0][k] = $urandom;
        bank[1][k] = $urandom;
      end
      s = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
      for (int k = 0; k < 4; k++) begin
        ea[k] = b + 32'(k * STRIDE);
        ed[k] = bank[s][k];
      end
      do_store(s, b, ea, ed, 0, 0, 1'b1, 0);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        sample();
        advance();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_vector_storer.md
PIXEL_VECTOR_STORER -- requirements
Module: pixel_vector_storer

Interface
Parameters:
REQ-001 SHALL have parameter W, default 32: lane data width and memory address width.
REQ-002 SHALL have parameter STRIDE, default 4: byte increment of the address between consecutive lane writes.

Ports:
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: request to store one vector; sampled in IDLE only.
REQ-006 SHALL have port vec_pos, input, 1: bank slot to store; captured with start.
REQ-007 SHALL have port base_addr, input, W: byte address of lane 1; captured with start.
REQ-008 SHALL have port rd_pos, output, 1: slot select driven to the pixel vector bank read port.
REQ-009 SHALL have ports in1..in4, input, W each: bank read data for lanes 1..4 (combinational from rd_pos).
REQ-010 SHALL have port mem_addr, output, W: data-memory write address.
REQ-011 SHALL have port mem_wd, output, W: data-memory write data.
REQ-012 SHALL have port mem_we, output, 1: write request; a beat completes on an edge where mem_we=1 and mem_ready=1.
REQ-013 SHALL have port mem_ready, input, 1: memory accepts the current beat; low stalls.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the final beat completes.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, WRITE and DONE.
REQ-017 SHALL move from IDLE to FETCH on an edge with start=1, latching vec_pos into a slot register and base_addr into an address register.
REQ-018 SHALL drive rd_pos from the slot register at all times; rd_pos is 0 after reset.
REQ-019 SHALL capture in1..in4 into a 4-entry lane buffer and move to WRITE with lane index 0 on the single FETCH cycle.
REQ-020 SHALL, in WRITE, drive mem_we=1, mem_wd=buffer[lane index] and mem_addr=address register.
REQ-021 SHALL hold mem_addr, mem_wd and mem_we stable while mem_ready=0, with no timeout.
REQ-022 SHALL, on each completed beat, increment the lane index and add STRIDE to the address register modulo 2^W (wrap-around, no error).
REQ-023 SHALL move from WRITE to DONE on completion of the beat with lane index 3.
REQ-024 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL write exactly 4 beats per start, in lane order 1,2,3,4.
REQ-026 SHALL ignore start while busy=1 (no queuing); start=1 held in DONE is not accepted until the IDLE cycle that follows.
REQ-027 SHALL take best-case latency from the start edge to the done pulse as 1 FETCH + 4 WRITE + 1 DONE cycle (done high in the 6th cycle after the start edge).
REQ-028 SHALL NOT reflect bank writes to the selected slot after FETCH in the stored data, because the lane buffer is a snapshot.
REQ-029 SHALL drive mem_we=0 outside WRITE; mem_addr and mem_wd are don't-care when mem_we=0 but hold their last values.

Reset
REQ-030 SHALL, on any edge with rst=1 (including mid-transfer), enter IDLE, clear the lane index, slot register, address register and lane buffer to 0, and drop mem_we, busy and done to 0 at that edge; rst has priority over start.
REQ-031 SHALL NOT complete an interrupted transfer after reset; beats already accepted by memory remain written.

Verification
REQ-032 SHALL verify the basic store: bank slot0 holds {15,45,74,82}, start with vec_pos=0 and base_addr=0x100, mem_ready=1 -> writes (0x100,15),(0x104,45),(0x108,74),(0x10C,82) on consecutive cycles, then done pulses once and busy falls.
REQ-033 SHALL verify slot select: slot1 holds {16,46,75,83} and start with vec_pos=1 -> rd_pos=1 and the four writes carry 16,46,75,83.
REQ-034 SHALL verify stalls: mem_ready=0 for 3 cycles during beat 2 -> the (0x104,45) outputs are held stable, no beat is skipped or duplicated, and done is delayed by 3 cycles.
REQ-035 SHALL verify address wrap: base_addr=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-036 SHALL verify start is ignored while busy: start pulses during WRITE and DONE -> exactly 4 beats and one done; a start in the following IDLE cycle begins a new transfer.
REQ-037 SHALL verify reset mid-operation: rst asserted after beat 2 -> mem_we=0, busy=0, done=0 and rd_pos=0 at the next edge, with no further beats.
